// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: shared types and constants for the MII receive monitor.
//   rx_state_t    - receive FSM states (IDLE, PRE, DATA, DROP)
//   PREAMBLE_NIB  - MII preamble nibble (4'h5)
//   SFD_NIB       - MII start-of-frame-delimiter nibble (4'hD)
//   DEF_*         - default values for the top-level parameters
package mac_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  localparam int DEF_MIN_BYTES = 64;
  localparam int DEF_MAX_BYTES = 1518;
  localparam int DEF_CNT_W     = 16;

  // 13-bit nibble counter; its upper 12 bits are the byte length, so the
  // 4095-byte ceiling of frame_len falls out of the counter saturation.
  localparam int NIB_W = 13;
  localparam int LEN_W = 12;

endpackage

// File: rtl/mac_sat_cnt.sv
// mac_sat_cnt: saturating up-counter with synchronous clear.
//   rx_clk   in  clock
//   n_hreset in  asynchronous active-low reset (count -> 0)
//   clr      in  synchronous clear; wins over inc
//   inc      in  increment enable
//   cnt      out current count, sticks at all-ones
module mac_sat_cnt #(
  parameter int W = 16
) (
  input  logic         rx_clk,
  input  logic         n_hreset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge rx_clk or negedge n_hreset) begin
    if (!n_hreset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/mac_rx_mon.sv
// mac_rx_mon: MII receive frame monitor.
// Parses rx_dv/rxd into preamble, SFD, data and end-of-frame events and
// publishes held per-frame status plus saturating good/bad counters.
//   rx_clk, n_hreset           clock, async active-low reset
//   rx_dv, rx_er, rxd, col, crs raw MII receive signals
//   clr_cnt                    single-cycle clear of both counters
//   rx_active                  registered rx_dv | crs
//   sof_tgl / eof_tgl          toggle per accepted SFD / completed frame
//   frame_len, frame_runt,
//   frame_long, frame_err      status of the last completed frame
//   good_cnt / bad_cnt         clean frames / flagged frames + dropped preambles
module mac_rx_mon
  import mac_rx_pkg::*;
#(
  parameter int MIN_BYTES = DEF_MIN_BYTES,
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             rx_clk,
  input  logic             n_hreset,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [3:0]       rxd,
  input  logic             col,
  input  logic             crs,
  input  logic             clr_cnt,
  output logic             rx_active,
  output logic             sof_tgl,
  output logic             eof_tgl,
  output logic [11:0]      frame_len,
  output logic             frame_runt,
  output logic             frame_long,
  output logic             frame_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  rx_state_t        state_reg, state_next;
  logic [NIB_W-1:0] nib_reg, nib_next;
  logic             err_reg, err_next;
  logic             sof_reg, sof_next;
  logic             eof_reg, eof_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             runt_reg, runt_next;
  logic             long_reg, long_next;
  logic             ferr_reg, ferr_next;
  logic             active_reg;
  logic             good_inc, bad_inc;

  // End-of-frame classification, evaluated from the count held at the
  // rx_dv=0 edge (the closing cycle itself adds no nibble).
  logic [LEN_W-1:0] len_calc;
  logic             runt_calc, long_calc, ferr_calc;

  assign len_calc  = nib_reg[NIB_W-1:1];
  assign runt_calc = (len_calc < MIN_LEN);
  assign long_calc = (len_calc > MAX_LEN);
  assign ferr_calc = err_reg | nib_reg[0];

  always_comb begin
    state_next = state_reg;
    nib_next   = nib_reg;
    err_next   = err_reg;
    sof_next   = sof_reg;
    eof_next   = eof_reg;
    len_next   = len_reg;
    runt_next  = runt_reg;
    long_next  = long_reg;
    ferr_next  = ferr_reg;
    good_inc   = 1'b0;
    bad_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        // rx_er without rx_dv is carrier extension / false carrier: ignored.
        if (rx_dv) begin
          state_next = (rxd == PREAMBLE_NIB) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!rx_dv) begin
          // Preamble abandoned before SFD: silently discarded.
          state_next = IDLE;
        end else if (rxd == SFD_NIB) begin
          state_next = DATA;
          nib_next   = '0;
          err_next   = 1'b0;
          sof_next   = ~sof_reg;
        end else if (rxd != PREAMBLE_NIB) begin
          state_next = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          if (nib_reg != '1) begin
            nib_next = nib_reg + 1'b1;
          end
          if (rx_er || col) begin
            err_next = 1'b1;
          end
        end else begin
          state_next = IDLE;
          len_next   = len_calc;
          runt_next  = runt_calc;
          long_next  = long_calc;
          ferr_next  = ferr_calc;
          eof_next   = ~eof_reg;
          if (runt_calc || long_calc || ferr_calc) begin
            bad_inc = 1'b1;
          end else begin
            good_inc = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          state_next = IDLE;
          bad_inc    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge n_hreset) begin
    if (!n_hreset) begin
      state_reg  <= IDLE;
      nib_reg    <= '0;
      err_reg    <= 1'b0;
      sof_reg    <= 1'b0;
      eof_reg    <= 1'b0;
      len_reg    <= '0;
      runt_reg   <= 1'b0;
      long_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      nib_reg    <= nib_next;
      err_reg    <= err_next;
      sof_reg    <= sof_next;
      eof_reg    <= eof_next;
      len_reg    <= len_next;
      runt_reg   <= runt_next;
      long_reg   <= long_next;
      ferr_reg   <= ferr_next;
      active_reg <= rx_dv | crs;
    end
  end

  mac_sat_cnt #(.W(CNT_W)) u_good_cnt (
    .rx_clk   (rx_clk),
    .n_hreset (n_hreset),
    .clr      (clr_cnt),
    .inc      (good_inc),
    .cnt      (good_cnt)
  );

  mac_sat_cnt #(.W(CNT_W)) u_bad_cnt (
    .rx_clk   (rx_clk),
    .n_hreset (n_hreset),
    .clr      (clr_cnt),
    .inc      (bad_inc),
    .cnt      (bad_cnt)
  );

  assign rx_active  = active_reg;
  assign sof_tgl    = sof_reg;
  assign eof_tgl    = eof_reg;
  assign frame_len  = len_reg;
  assign frame_runt = runt_reg;
  assign frame_long = long_reg;
  assign frame_err  = ferr_reg;

endmodule
